pe_controller: RTL and testbench

Sequencer for one processing element: drives the filter-buffer enables, MAC-operand select, MAC clear/enable, result shift-register enable, and OFM address/write strobe. On `start` it loads a 16-tap filter from OFM memory, then produces `num_out` OFM words. Each word holds four 16-tap dot products. Each product uses a streamed IFM operand (`mac2_in`) under a valid/ready handshake. It sits directly upstream of the PE datapath and owns every PE control input.

---
 rtl/pe_controller.sv | 219 +++++++++++++++++++++
 tb/tb_pe_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_controller.sv
`default_nettype none
// ============================================================================
// Module      : pe_controller
// Description : Sequencer for one processing element.
//               On start it loads a FILT_LEN-tap filter from OFM memory
//               (PACK bytes per word), then produces num_out OFM words.
//               Each word packs PACK dot products of FILT_LEN taps, and the
//               IFM operands arrive under a valid/ready handshake.
//
//   Ports
//     clk, rst    : clock (rising edge), synchronous active-high reset
//     start       : one-cycle request, honoured only when idle
//     filt_base   : OFM address of the first filter word (latched at start)
//     out_base    : OFM address of the first result word (latched at start)
//     num_out     : number of OFM words to produce (latched at start)
//     ifm_valid   : the IFM operand is valid this cycle
//     ifm_ready   : operand consumed this cycle when ifm_valid is also high
//     en1         : filter-buffer byte enables
//     sel         : filter tap select into the MAC
//     en12        : MAC accumulate enable
//     rst12       : MAC synchronous clear
//     en10        : result shift-register shift enable
//     wr          : OFM write strobe
//     addr        : OFM address, shared by filter reads and result writes
//     busy        : high in every state except idle
//     done        : one-cycle completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module pe_controller #(
    parameter int FILT_LEN = 16,
    parameter int PACK     = 4,
    parameter int ADDR_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           filt_base,
    input  logic [ADDR_W-1:0]           out_base,
    input  logic [7:0]                  num_out,
    input  logic                        ifm_valid,
    output logic                        ifm_ready,
    output logic [FILT_LEN-1:0]         en1,
    output logic [$clog2(FILT_LEN)-1:0] sel,
    output logic                        en12,
    output logic                        rst12,
    output logic                        en10,
    output logic                        wr,
    output logic [ADDR_W-1:0]           addr,
    output logic                        busy,
    output logic                        done
);

    localparam int c_SEL_W  = $clog2(FILT_LEN);
    localparam int c_NLOAD  = FILT_LEN / PACK;
    localparam int c_K_W    = (c_NLOAD > 1) ? $clog2(c_NLOAD) : 1;
    localparam int c_R_W    = $clog2(PACK + 1);

    localparam logic [c_K_W-1:0]   c_K_LAST = c_K_W'(c_NLOAD - 1);
    localparam logic [c_SEL_W-1:0] c_T_LAST = c_SEL_W'(FILT_LEN - 1);
    localparam logic [c_R_W-1:0]   c_R_FULL = c_R_W'(PACK);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_CLEAR = 3'd2;
    localparam logic [2:0] c_S_MAC   = 3'd3;
    localparam logic [2:0] c_S_SHIFT = 3'd4;
    localparam logic [2:0] c_S_WRITE = 3'd5;
    localparam logic [2:0] c_S_DONE  = 3'd6;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_K_W-1:0]   r_k,     w_k_nxt;      // filter-load word index
    logic [c_SEL_W-1:0] r_t,     w_t_nxt;      // tap index
    logic [c_R_W-1:0]   r_r,     w_r_nxt;      // results packed into current word
    logic [7:0]         r_w,     w_w_nxt;      // OFM word index
    logic [ADDR_W-1:0]  r_filt_base;
    logic [ADDR_W-1:0]  r_out_base;
    logic [7:0]         r_num_out;

    logic               w_launch;
    logic [c_R_W-1:0]   w_r_inc;
    logic [7:0]         w_w_inc;

    assign w_launch = (r_state == c_S_IDLE) && start;
    assign w_r_inc  = r_r + c_R_W'(1);
    assign w_w_inc  = r_w + 8'd1;

    // ------------------------------------------------------------------
    // State and counter registers; run parameters are captured only on
    // an accepted start so a start while busy cannot disturb them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_k         <= '0;
            r_t         <= '0;
            r_r         <= '0;
            r_w         <= '0;
            r_filt_base <= '0;
            r_out_base  <= '0;
            r_num_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_t     <= w_t_nxt;
            r_r     <= w_r_nxt;
            r_w     <= w_w_nxt;
            if (w_launch) begin
                r_filt_base <= filt_base;
                r_out_base  <= out_base;
                r_num_out   <= num_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_t_nxt     = r_t;
        w_r_nxt     = r_r;
        w_w_nxt     = r_w;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_LOAD;
                    w_k_nxt     = '0;
                end
            end
            c_S_LOAD: begin
                if (r_k == c_K_LAST) begin
                    w_w_nxt = '0;
                    w_r_nxt = '0;
                    w_state_nxt = (r_num_out == 8'd0) ? c_S_DONE : c_S_CLEAR;
                end else begin
                    w_k_nxt = r_k + c_K_W'(1);
                end
            end
            c_S_CLEAR: begin
                w_state_nxt = c_S_MAC;
                w_t_nxt     = '0;
            end
            c_S_MAC: begin
                // A missing operand stalls here with the tap held.
                if (ifm_valid) begin
                    if (r_t == c_T_LAST) begin
                        w_state_nxt = c_S_SHIFT;
                    end else begin
                        w_t_nxt = r_t + c_SEL_W'(1);
                    end
                end
            end
            c_S_SHIFT: begin
                w_r_nxt     = w_r_inc;
                w_state_nxt = (w_r_inc == c_R_FULL) ? c_S_WRITE : c_S_CLEAR;
            end
            c_S_WRITE: begin
                w_w_nxt     = w_w_inc;
                w_r_nxt     = '0;
                w_state_nxt = (w_w_inc == r_num_out) ? c_S_DONE : c_S_CLEAR;
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is Moore except en12, which follows
    // ifm_valid directly so an operand is accepted in the cycle offered.
    // ------------------------------------------------------------------
    always_comb begin
        ifm_ready = 1'b0;
        en1       = '0;
        sel       = '0;
        en12      = 1'b0;
        rst12     = 1'b0;
        en10      = 1'b0;
        wr        = 1'b0;
        busy      = (r_state != c_S_IDLE);
        done      = 1'b0;
        addr      = (r_state == c_S_IDLE) ? '0 : (r_out_base + ADDR_W'(r_w));
        case (r_state)
            c_S_LOAD: begin
                addr = r_filt_base + ADDR_W'(r_k);
                // One PACK-byte group of the filter buffer per load word.
                for (int i = 0; i < FILT_LEN; i++) begin
                    en1[i] = ((i / PACK) == int'(r_k));
                end
            end
            c_S_CLEAR: begin
                rst12 = 1'b1;
            end
            c_S_MAC: begin
                ifm_ready = 1'b1;
                sel       = r_t;
                en12      = ifm_valid;
            end
            c_S_SHIFT: begin
                en10 = 1'b1;
            end
            c_S_WRITE: begin
                wr = 1'b1;
            end
            c_S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_controller
// Description : Self-checking bench for pe_controller. A small PE datapath
//               model (filter buffer, MAC, shift register, OFM memory) is
//               driven by the controller outputs; results are compared with
//               dot products computed directly from the filter and operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_controller;

    localparam int FILT_LEN = 16;
    localparam int PACK     = 4;
    localparam int ADDR_W   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  filt_base, out_base, num_out;
    logic        ifm_valid;
    logic        ifm_ready;
    logic [15:0] en1;
    logic [3:0]  sel;
    logic        en12, rst12, en10, wr, busy, done;
    logic [7:0]  addr;

    always #5 clk = ~clk;

    pe_controller #(.FILT_LEN(FILT_LEN), .PACK(PACK), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_base(filt_base), .out_base(out_base), .num_out(num_out),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .en1(en1), .sel(sel), .en12(en12), .rst12(rst12), .en10(en10),
        .wr(wr), .addr(addr), .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // PE datapath model and run results
    logic [31:0] mem [0:255];
    logic [7:0]  filt_model [0:15];
    logic [7:0]  filt_ref [0:15];
    logic [7:0]  ops [$];
    logic [7:0]  wr_q [$];
    logic [7:0]  mac2_in;
    logic [31:0] acc, sr;
    int          done_cyc, stalls;

    typedef struct {
        logic [7:0] fb;
        logic [7:0] ob;
        logic [7:0] n;
        int         vmode;    // 0 always valid, 1 alternate, 2 random
        int         fill;     // 0 random data, 1 all-ones filter with ramp operands
        int         inject;   // cycle at which a stray start is pulsed, -1 none
        int         exp_done;
        int         exp_wr;
        logic [7:0] wr0;
        logic [7:0] wrl;
    } vec_t;

    task automatic run_case(input logic [7:0] fb, input logic [7:0] ob, input logic [7:0] n,
                            input int vmode, input int fill, input int inject, input string tag);
        int nn, budget, cyc, accs, shifts, ready_cnt, idx;
        int busy_err, load_err, en12_err, sel_err, order_err;
        int rst12_cnt, en12_cnt, en10_cnt;
        bit got_done, prev_en12, prev_en10, v;
        logic [7:0]  a;
        logic [15:0] exp_en1;
        logic [31:0] word, sum;
        nn = int'(n);
        for (int k = 0; k < 4; k++) begin
            a = fb + 8'(k);
            mem[a] = (fill != 0) ? 32'h0101_0101 : $urandom;
        end
        for (int t = 0; t < 16; t++) begin
            a = fb + 8'(t / 4);
            filt_ref[t]   = mem[a][8*(t%4) +: 8];
            filt_model[t] = 8'h00;
        end
        ops.delete();
        for (int i = 0; i < 64 * nn; i++) ops.push_back((fill != 0) ? 8'(i + 1) : 8'($urandom));
        wr_q.delete();
        acc = 0; sr = 0; idx = 0; accs = 0; shifts = 0; ready_cnt = 0; stalls = 0;
        busy_err = 0; load_err = 0; en12_err = 0; sel_err = 0; order_err = 0;
        rst12_cnt = 0; en12_cnt = 0; en10_cnt = 0;
        got_done = 0; prev_en12 = 0; prev_en10 = 0; done_cyc = -1;
        budget = 40 + 200 * nn;

        @(negedge clk);
        filt_base = fb; out_base = ob; num_out = n; start = 1'b1; ifm_valid = 1'b0;
        @(negedge clk);
        for (cyc = 0; cyc < budget; cyc++) begin
            if (cyc == inject) begin
                start = 1'b1; filt_base = ~fb; out_base = ob + 8'd100; num_out = n + 8'd1;
            end else begin
                start = 1'b0;
            end
            case (vmode)
                0: v = 1'b1;
                1: v = ifm_ready && (ready_cnt % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            ifm_valid = v;
            mac2_in = (idx < ops.size()) ? ops[idx] : 8'h00;
            #1;
            if (!busy) busy_err++;
            exp_en1 = (cyc < 4) ? (16'h000F << (4 * cyc)) : 16'h0000;
            if (en1 !== exp_en1) load_err++;
            if (cyc < 4 && addr !== fb + 8'(cyc)) load_err++;
            if (en12 !== (ifm_ready & ifm_valid)) en12_err++;
            if (ifm_ready && sel !== 4'(accs)) sel_err++;
            if (ifm_ready && !ifm_valid) stalls++;
            if (ifm_ready) ready_cnt++;
            if (rst12) begin rst12_cnt++; acc = 0; accs = 0; end
            if (en12) begin
                en12_cnt++;
                acc = acc + 32'(filt_model[sel]) * 32'(mac2_in);
                accs++; idx++;
            end
            if (en10) begin
                if (!prev_en12 || accs != 16) order_err++;
                sr = {sr[23:0], acc[7:0]};
                en10_cnt++; shifts++;
            end
            if (wr) begin
                if (!prev_en10 || shifts != 4) order_err++;
                mem[addr] = sr;
                wr_q.push_back(addr);
                shifts = 0;
            end
            for (int i = 0; i < 16; i++) if (en1[i]) filt_model[i] = mem[addr][8*(i%4) +: 8];
            prev_en12 = en12; prev_en10 = en10;
            if (done) begin done_cyc = cyc; got_done = 1; end
            if (got_done) break;
            @(negedge clk);
        end
        start = 1'b0; ifm_valid = 1'b0;
        check({tag, "_done_seen"}, got_done, 1);
        @(negedge clk); #1;
        check({tag, "_idle_after_done"}, {busy, done, wr, en12}, 0);

        check({tag, "_busy"}, busy_err, 0);
        check({tag, "_load"}, load_err, 0);
        check({tag, "_en12_handshake"}, en12_err, 0);
        check({tag, "_sel_track"}, sel_err, 0);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_rst12_cnt"}, rst12_cnt, 4 * nn);
        check({tag, "_en12_cnt"}, en12_cnt, 64 * nn);
        check({tag, "_en10_cnt"}, en10_cnt, 4 * nn);
        check({tag, "_wr_cnt"}, wr_q.size(), nn);
        check({tag, "_done_time"}, done_cyc, 4 + 73 * nn + stalls);
        for (int w = 0; w < nn && w < wr_q.size(); w++) begin
            check({tag, "_wr_addr"}, wr_q[w], 8'(ob + 8'(w)));
            word = 0;
            for (int r = 0; r < 4; r++) begin
                sum = 0;
                for (int t = 0; t < 16; t++) sum += 32'(filt_ref[t]) * 32'(ops[64*w + 16*r + t]);
                word = {word[23:0], sum[7:0]};
            end
            a = ob + 8'(w);
            check({tag, "_ofm_data"}, mem[a], word);
        end
    endtask

    task automatic reset_mid_run();
        int cnt, wr_seen, en10_seen, busy_seen;
        bit hit;
        cnt = 0; hit = 0; wr_seen = 0; en10_seen = 0; busy_seen = 0;
        @(negedge clk);
        filt_base = 8'h10; out_base = 8'h40; num_out = 8'd1; start = 1'b1; ifm_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            #1;
            if (en12) cnt++;
            if (cnt == 3) begin rst = 1'b1; hit = 1; end
            else @(negedge clk);
        end
        check("rst_third_en12_reached", hit, 1);
        @(posedge clk); #1;
        check("rst_next_cycle_idle",
              {busy, done, wr, en10, en12, rst12, ifm_ready, en1, addr, sel}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (wr) wr_seen++;
            if (en10) en10_seen++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check("rst_no_wr_after", wr_seen, 0);
        check("rst_no_en10_after", en10_seen, 0);
        check("rst_stays_idle", busy_seen, 0);
    endtask

    initial begin
        vec_t vecs [6];
        logic [7:0] fb, ob, n;

        vecs[0] = '{8'h10, 8'h40, 8'd1, 0, 0, -1,  77, 1, 8'h40, 8'h40};  // basic
        vecs[1] = '{8'h10, 8'h40, 8'd1, 1, 0, -1, 141, 1, 8'h40, 8'h40};  // alternating stalls
        vecs[2] = '{8'h20, 8'hFF, 8'd2, 0, 0, -1, 150, 2, 8'hFF, 8'h00};  // address wrap
        vecs[3] = '{8'h30, 8'h50, 8'd0, 0, 0, -1,   4, 0, 8'h00, 8'h00};  // zero words
        vecs[4] = '{8'h10, 8'h60, 8'd1, 0, 0, 10,  77, 1, 8'h60, 8'h60};  // start while busy
        vecs[5] = '{8'h80, 8'h90, 8'd1, 0, 1, -1,  77, 1, 8'h90, 8'h90};  // ones filter, ramp IFM

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b1; ifm_valid = 1'b0;
        filt_base = 8'h00; out_base = 8'h00; num_out = 8'd3; mac2_in = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outputs_zero",
                  {busy, done, wr, en10, en12, rst12, ifm_ready, en1, addr, sel}, 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("reset_no_load", {busy, en1}, 0);

        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i].fb, vecs[i].ob, vecs[i].n, vecs[i].vmode, vecs[i].fill,
                     vecs[i].inject, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_done_abs", i), done_cyc, vecs[i].exp_done);
            check($sformatf("vec%0d_wr_count", i), wr_q.size(), vecs[i].exp_wr);
            if (vecs[i].exp_wr > 0 && wr_q.size() > 0) begin
                check($sformatf("vec%0d_wr_first", i), wr_q[0], vecs[i].wr0);
                check($sformatf("vec%0d_wr_last", i), wr_q[wr_q.size()-1], vecs[i].wrl);
            end
        end

        reset_mid_run();
        run_case(8'h10, 8'h40, 8'd1, 0, 0, -1, "after_rst");
        check("after_rst_done_abs", done_cyc, 77);

        for (int i = 0; i < 6; i++) begin
            fb = 8'($urandom);
            ob = fb + 8'd4 + 8'($urandom_range(0, 247));
            n  = 8'($urandom_range(1, 3));
            run_case(fb, ob, n, 2, 0, -1, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
